// File: rtl/approx_mul_pkg.sv
// Shared types and widths for the 8x8 approximate-multiplier characterisation blocks.
package approx_mul_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
    localparam int CNT_W  = 17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } es_state_t;

endpackage

// File: rtl/ed_calc.sv
// S1->S2 stage: exact product of the registered operands and the registered
// error distance |exact - approximate| with a nonzero flag.
module ed_calc #(
    parameter int OP_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OP_W-1:0]     i_a,
    input  logic [OP_W-1:0]     i_b,
    input  logic [2*OP_W-1:0]   i_prod_apx,
    output logic [2*OP_W-1:0]   o_ed,
    output logic                o_nz
);

    localparam int PW = 2 * OP_W;

    logic [PW-1:0]        w_exact;
    logic signed [PW:0]   w_diff;
    logic signed [PW:0]   w_neg;
    logic [PW-1:0]        w_ed;

    // One extra bit keeps the signed difference exact for every operand pair,
    // so the magnitude always fits back into PW bits.
    always_comb begin
        w_exact = PW'(i_a) * PW'(i_b);
        w_diff  = $signed({1'b0, w_exact}) - $signed({1'b0, i_prod_apx});
        w_neg   = -w_diff;
        w_ed    = w_diff[PW] ? PW'(w_neg) : PW'(w_diff);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_ed <= '0;
            o_nz <= 1'b0;
        end else begin
            o_ed <= w_ed;
            o_nz <= |w_ed;
        end
    end

endmodule

// File: rtl/err_stat_8x8.sv
// Streaming error-statistics collector: accepts (a, b, approximate product)
// triples, and accumulates error count, ED sum and max ED over N_SAMPLES.
module err_stat_8x8
    import approx_mul_pkg::*;
#(
    parameter int N_SAMPLES = 65536,
    parameter int ACC_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_W-1:0]      a,
    input  logic [OP_W-1:0]      b,
    input  logic [PROD_W-1:0]    prod_apx,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [ACC_W-1:0]     ed_sum,
    output logic [PROD_W-1:0]    ed_max,
    output logic [CNT_W-1:0]     smp_cnt
);

    localparam logic [CNT_W-1:0] N_LIM = CNT_W'(N_SAMPLES);

    es_state_t            r_state;
    es_state_t            w_state_nxt;
    logic [CNT_W-1:0]     r_acc_cnt;
    logic [1:0]           r_vld_pipe;
    logic [OP_W-1:0]      r_a;
    logic [OP_W-1:0]      r_b;
    logic [PROD_W-1:0]    r_prod;
    logic [PROD_W-1:0]    w_ed;
    logic                 w_nz;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_clear;
    logic [ACC_W:0]       w_sum;
    logic [CNT_W-1:0]     r_err_cnt;
    logic [ACC_W-1:0]     r_ed_sum;
    logic [PROD_W-1:0]    r_ed_max;
    logic [CNT_W-1:0]     r_smp_cnt;

    assign in_ready = (r_state == ST_RUN) && (r_acc_cnt < N_LIM);
    assign w_accept = in_valid && in_ready;
    assign w_last   = w_accept && (r_acc_cnt == N_LIM - 1'b1);
    assign w_clear  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    assign busy     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done     = (r_state == ST_DONE);
    assign err_cnt  = r_err_cnt;
    assign ed_sum   = r_ed_sum;
    assign ed_max   = r_ed_max;
    assign smp_cnt  = r_smp_cnt;

    // DRAIN exits once S1 is empty; the sample still in S2 retires on that
    // same edge, so done and the final statistics appear together.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start)          w_state_nxt = ST_RUN;
            ST_RUN:   if (w_last)         w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!r_vld_pipe[0]) w_state_nxt = ST_DONE;
            ST_DONE:  if (start)          w_state_nxt = ST_RUN;
            default:                      w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_vld_pipe <= '0;
        else        r_vld_pipe <= {r_vld_pipe[0], w_accept};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_prod <= '0;
        end else if (w_accept) begin
            r_a    <= a;
            r_b    <= b;
            r_prod <= prod_apx;
        end
    end

    ed_calc #(.OP_W(OP_W)) u_ed_calc (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_a        (r_a),
        .i_b        (r_b),
        .i_prod_apx (r_prod),
        .o_ed       (w_ed),
        .o_nz       (w_nz)
    );

    assign w_sum = {1'b0, r_ed_sum} + (ACC_W+1)'(w_ed);

    // A clear only happens in IDLE/DONE, where the pipeline is already empty.
    always_ff @(posedge clk) begin
        if (!rst_n || w_clear) begin
            r_acc_cnt <= '0;
            r_err_cnt <= '0;
            r_ed_sum  <= '0;
            r_ed_max  <= '0;
            r_smp_cnt <= '0;
        end else begin
            if (w_accept) r_acc_cnt <= r_acc_cnt + 1'b1;
            if (r_vld_pipe[1]) begin
                r_smp_cnt <= r_smp_cnt + 1'b1;
                r_err_cnt <= r_err_cnt + CNT_W'(w_nz);
                r_ed_sum  <= w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
                if (w_ed > r_ed_max) r_ed_max <= w_ed;
            end
        end
    end

endmodule

// File: tb/tb_err_stat_8x8.sv
// Directed bench: four collector instances (N=4, 1, 100, 65536) on a shared
// operand bus, each started independently.
module tb_err_stat_8x8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start [4];
    logic        in_valid;
    logic [7:0]  a, b;
    logic [15:0] prod_apx;
    logic        rdy [4];
    logic        bsy [4];
    logic        dn  [4];
    logic [16:0] ec  [4];
    logic [31:0] es  [4];
    logic [15:0] em  [4];
    logic [16:0] sc  [4];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    err_stat_8x8 #(.N_SAMPLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .in_valid(in_valid), .in_ready(rdy[0]),
        .a(a), .b(b), .prod_apx(prod_apx), .busy(bsy[0]), .done(dn[0]),
        .err_cnt(ec[0]), .ed_sum(es[0]), .ed_max(em[0]), .smp_cnt(sc[0]));

    err_stat_8x8 #(.N_SAMPLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .in_valid(in_valid), .in_ready(rdy[1]),
        .a(a), .b(b), .prod_apx(prod_apx), .busy(bsy[1]), .done(dn[1]),
        .err_cnt(ec[1]), .ed_sum(es[1]), .ed_max(em[1]), .smp_cnt(sc[1]));

    err_stat_8x8 #(.N_SAMPLES(100)) dut100 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .in_valid(in_valid), .in_ready(rdy[2]),
        .a(a), .b(b), .prod_apx(prod_apx), .busy(bsy[2]), .done(dn[2]),
        .err_cnt(ec[2]), .ed_sum(es[2]), .ed_max(em[2]), .smp_cnt(sc[2]));

    err_stat_8x8 dutf (
        .clk(clk), .rst_n(rst_n), .start(start[3]), .in_valid(in_valid), .in_ready(rdy[3]),
        .a(a), .b(b), .prod_apx(prod_apx), .busy(bsy[3]), .done(dn[3]),
        .err_cnt(ec[3]), .ed_sum(es[3]), .ed_max(em[3]), .smp_cnt(sc[3]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input int d, input string tag, input longint e_err,
                             input longint e_sum, input longint e_max, input longint e_smp);
        chk({tag, "_err_cnt"}, 64'(ec[d]), e_err);
        chk({tag, "_ed_sum"},  64'(es[d]), e_sum);
        chk({tag, "_ed_max"},  64'(em[d]), e_max);
        chk({tag, "_smp_cnt"}, 64'(sc[d]), e_smp);
    endtask

    task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv, input logic [15:0] pv);
        in_valid = v;
        a        = av;
        b        = bv;
        prod_apx = pv;
    endtask

    task automatic pulse_start(input int d);
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input string tag);
        int n;
        n = 0;
        while (!dn[d] && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, 64'(dn[d]), 1);
    endtask

    initial begin
        logic [7:0]  av, bv;
        logic [15:0] pv;
        logic        v;
        int          i, cyc;

        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) start[k] = 1'b0;
        drive(1'b0, 8'd0, 8'd0, 16'd0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_in_ready", 64'(rdy[0]), 0);
        chk("rst_busy", 64'(bsy[0]), 0);
        chk("rst_done", 64'(dn[0]), 0);
        chk_stats(0, "rst", 0, 0, 0, 0);

        // N=4 directed run, with a start pulse mid-RUN that must be ignored
        pulse_start(0);
        chk("n4_ready", 64'(rdy[0]), 1);
        chk("n4_busy", 64'(bsy[0]), 1);
        drive(1'b1, 8'd0, 8'd0, 16'd1);
        tick();
        drive(1'b1, 8'd255, 8'd255, 16'd65025);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        chk("n4_lat_k1_smp", 64'(sc[0]), 0);
        drive(1'b1, 8'd15, 8'd15, 16'd200);
        tick();
        chk("n4_lat_k2_smp", 64'(sc[0]), 1);
        chk("n4_lat_k2_sum", 64'(es[0]), 1);
        drive(1'b1, 8'd3, 8'd4, 16'd12);
        tick();
        chk("n4_ready_drop", 64'(rdy[0]), 0);
        chk("n4_drain_busy", 64'(bsy[0]), 1);
        chk("n4_drain_done", 64'(dn[0]), 0);
        drive(1'b0, 8'd0, 8'd0, 16'd0);
        tick();
        chk("n4_drain2_done", 64'(dn[0]), 0);
        tick();
        chk("n4_done", 64'(dn[0]), 1);
        chk("n4_done_busy", 64'(bsy[0]), 0);
        chk_stats(0, "n4", 2, 26, 25, 4);

        // Restart from DONE clears on the start edge, then a fresh run
        pulse_start(0);
        chk_stats(0, "n4_clr", 0, 0, 0, 0);
        chk("n4_clr_done", 64'(dn[0]), 0);
        chk("n4_clr_busy", 64'(bsy[0]), 1);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 8'd10, 8'd10, 16'd90);
            tick();
        end
        drive(1'b0, 8'd0, 8'd0, 16'd0);
        wait_done(0, "n4b");
        chk_stats(0, "n4b", 4, 40, 10, 4);

        // N=1, maximum ED; done exactly two edges after acceptance
        pulse_start(1);
        drive(1'b1, 8'd0, 8'd0, 16'd65535);
        tick();
        drive(1'b0, 8'd0, 8'd0, 16'd0);
        chk("n1_ready", 64'(rdy[1]), 0);
        chk("n1_done_k0", 64'(dn[1]), 0);
        tick();
        chk("n1_done_k1", 64'(dn[1]), 0);
        tick();
        chk("n1_done_k2", 64'(dn[1]), 1);
        chk_stats(1, "n1", 1, 65535, 65535, 1);

        // N=100 with random valid; every 10th sample off by +3
        pulse_start(2);
        i = 0;
        cyc = 0;
        while (i < 100 && cyc < 2000) begin
            v  = 1'(($urandom % 2));
            av = 8'($urandom);
            bv = 8'($urandom);
            pv = 16'({8'd0, av} * {8'd0, bv}) + ((i % 10 == 9) ? 16'd3 : 16'd0);
            drive(v, av, bv, pv);
            if (v && rdy[2]) i++;
            tick();
            cyc++;
        end
        drive(1'b0, 8'd0, 8'd0, 16'd0);
        wait_done(2, "rnd");
        chk_stats(2, "rnd", 10, 30, 3, 100);
        chk_stats(0, "n4_hold", 4, 40, 10, 4);

        // Reset after 50 of 100 samples discards everything
        pulse_start(2);
        for (int k = 0; k < 50; k++) begin
            drive(1'b1, 8'(k), 8'd3, 16'(k * 3));
            tick();
        end
        drive(1'b0, 8'd0, 8'd0, 16'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_stats(2, "mrst", 0, 0, 0, 0);
        chk("mrst_ready", 64'(rdy[2]), 0);
        chk("mrst_busy", 64'(bsy[2]), 0);
        chk("mrst_done", 64'(dn[2]), 0);
        drive(1'b1, 8'd7, 8'd7, 16'd0);
        tick();
        tick();
        tick();
        chk("mrst_idle_ready", 64'(rdy[2]), 0);
        chk("mrst_idle_smp", 64'(sc[2]), 0);
        chk("mrst_n4_smp", 64'(sc[0]), 0);
        drive(1'b0, 8'd0, 8'd0, 16'd0);

        // Exhaustive sweep with an exact multiplier
        pulse_start(3);
        for (int j = 0; j < 65536; j++) begin
            av = 8'(j >> 8);
            bv = 8'(j);
            drive(1'b1, av, bv, 16'({8'd0, av} * {8'd0, bv}));
            tick();
        end
        drive(1'b0, 8'd0, 8'd0, 16'd0);
        chk("full_ready", 64'(rdy[3]), 0);
        wait_done(3, "full");
        chk_stats(3, "full", 0, 0, 0, 65536);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/err_stat_8x8.md
# err_stat_8x8

- Streaming error-statistics collector for the 8x8 approximate multipliers.
- Sits directly downstream of an approximate multiplier such as a split-operand hybrid design.
- Per accepted operand pair, consumes the operands and the approximate 16-bit product, forms the exact product internally and computes the error distance (ED).
- Accumulates error count, ED sum and maximum ED over a programmed number of samples, then raises `done`. Used for on-FPGA characterisation sweeps.

## Interface
Parameters:
- `N_SAMPLES`, 65536: samples per run (65536 = exhaustive 8x8 sweep); legal 1..65536.
- `ACC_W`, 32: width of ED-sum accumulator; must be ≥ 32 for exhaustive sweeps.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: one-cycle pulse; begins a run from IDLE or DONE.
- `in_valid` in 1: operand/product triple valid.
- `in_ready` out 1: block accepts the triple this cycle.
- `a` in 8: multiplicand, unsigned.
- `b` in 8: multiplier, unsigned.
- `prod_apx` in 16: approximate product of `a`,`b`.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: high in DONE (level, not pulse).
- `err_cnt` out 17: samples with ED ≠ 0.
- `ed_sum` out ACC_W: Σ ED.
- `ed_max` out 16: largest ED seen.
- `smp_cnt` out 17: samples accumulated.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: `start` → RUN; clears all statistics and counters in the same edge.
  - RUN: accepts while `in_ready`; when accepted count reaches `N_SAMPLES` → DRAIN.
  - DRAIN: waits until the pipeline is empty → DONE.
  - DONE: holds results; `start` → RUN with clear, same as from IDLE.
- `in_ready` = (state == RUN) && (accepted < N_SAMPLES). Transfer occurs when `in_valid && in_ready`.
- Arithmetic:
  - Exact product is the 16-bit unsigned `a*b`.
  - ED = |exact − prod_apx|, 16-bit unsigned, computed via a 17-bit signed difference. Max ED is 65535 (exact 0, apx 65535).
- Accumulation per retired sample:
  - `smp_cnt` += 1.
  - `err_cnt` += (ED ≠ 0).
  - `ed_sum` += ED, saturating at all-ones.
  - `ed_max` = max(`ed_max`, ED).
- `start` during RUN or DRAIN is ignored.
- `in_valid` outside RUN is ignored; no statistic changes.
- Results remain stable in DONE until the next `start` or reset.

## Timing
- Reset (`rst_n` low at an edge): state IDLE; `in_ready`, `busy`, `done` = 0; `err_cnt`, `ed_sum`, `ed_max`, `smp_cnt` = 0; pipeline valids cleared. Reset mid-run discards in-flight samples.
- Pipeline, 3 stages:
  - S1 registers `a`, `b`, `prod_apx`.
  - S2 registers the exact product and ED.
  - S3 updates the accumulators.
- A triple accepted at edge k is visible in the statistic outputs after edge k+2.
- Full throughput: one sample per cycle; no internal stalls.
- `in_ready` drops combinationally in the cycle after the `N_SAMPLES`-th acceptance (state leaves RUN).
- DRAIN lasts exactly 2 cycles. `done` rises at the edge where the last sample is accumulated. `busy` falls at the same edge.
- `start` coincident with reset: reset wins.
- Upstream may deassert `in_valid` arbitrarily; bubbles propagate as invalid stages.

## Structure
- Shared package `approx_mul_pkg`:
  - FSM state enum `es_state_t`.
  - Constants `OP_W=8`, `PROD_W=16`, `CNT_W=17`.
- One sub-module `ed_calc`: registered exact product plus absolute difference (S1→S2), parameterised on `OP_W`.
- Top holds the FSM, accept counter and S3 accumulators.

## Test plan
- Exact multiplier (`prod_apx = a*b`), exhaustive 65536 samples → `err_cnt=0`, `ed_sum=0`, `ed_max=0`, `smp_cnt=65536`, `done=1`.
- `N_SAMPLES=4`; triples (0,0,1), (255,255,65025), (15,15,200), (3,4,12) → `err_cnt=2`, `ed_sum=26`, `ed_max=25`.
- `a=0`, `b=0`, `prod_apx=65535`, `N_SAMPLES=1` → `ed_max=65535`, `ed_sum=65535`; `done` 2 edges after acceptance.
- Random `in_valid` (50%) over 100 samples with exact products except every 10th off by +3 → `err_cnt=10`, `ed_sum=30`; no samples lost or duplicated.
- `start` pulsed mid-RUN → ignored, counts unaffected. `start` in DONE → outputs clear next edge and a new run completes.
- `rst_n` low for one cycle after 50 of 100 samples → all outputs 0, state IDLE, `in_ready=0` until the next `start`.
